wrr_arbiter: RTL and testbench

WRR_ARBITER -- requirements
Module: wrr_arbiter

---
 rtl/wrr_arbiter.sv | 108 ++++++++++
 tb/tb_wrr_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// Weighted round-robin / fixed-priority arbiter with per-requester beat credits
// and grant lock. One-hot registered grant, one-cycle arbitration latency.
module wrr_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int WEIGHT_W       = 4,
  localparam int IDX_W         = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQUESTERS-1:0]          i_requests,
  input  logic [NUM_REQUESTERS*WEIGHT_W-1:0] i_weights,
  input  logic [NUM_REQUESTERS-1:0]          i_lock,
  input  logic                               i_mode,
  input  logic                               i_ready,
  output logic [NUM_REQUESTERS-1:0]          o_grants,
  output logic                               o_grant_valid,
  output logic [IDX_W-1:0]                   o_grant_idx,
  output logic                               o_dbg_state
);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_GRANT = 1'b1;

  logic                      r_state;
  logic [NUM_REQUESTERS-1:0] r_grants;
  logic [IDX_W-1:0]          r_idx;
  logic [IDX_W-1:0]          r_last_idx;
  logic [WEIGHT_W-1:0]       r_credit;

  logic                w_any_req;
  logic                w_found;
  logic [IDX_W-1:0]    w_win_idx;
  int                  w_cand;
  logic [WEIGHT_W-1:0] w_win_weight;
  logic [WEIGHT_W-1:0] w_load_credit;
  logic                w_beat;
  logic                w_lock_h;
  logic                w_release;
  logic                w_expire;
  logic                w_decide;

  assign w_any_req = |i_requests;

  // Winner search: fixed priority scans from 0; round-robin starts one past the last holder.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_cand    = 0;
    if (i_mode) begin
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
        if (!w_found && i_requests[k]) begin
          w_found   = 1'b1;
          w_win_idx = IDX_W'(k);
        end
      end
    end else begin
      for (int off = 1; off <= NUM_REQUESTERS; off++) begin
        w_cand = (int'(r_last_idx) + off) % NUM_REQUESTERS;
        if (!w_found && i_requests[w_cand]) begin
          w_found   = 1'b1;
          w_win_idx = IDX_W'(w_cand);
        end
      end
    end
  end

  assign w_win_weight  = i_weights[int'(w_win_idx)*WEIGHT_W +: WEIGHT_W];
  assign w_load_credit = (w_win_weight == '0) ? WEIGHT_W'(1) : w_win_weight;

  // Handshake: a beat is o_grant_valid && i_ready in the same cycle; i_ready may
  // toggle freely and the grant never depends on it combinationally.
  assign w_beat    = o_grant_valid && i_ready;
  assign w_lock_h  = i_lock[r_idx];
  assign w_release = !w_lock_h && !i_requests[r_idx];
  assign w_expire  = w_beat && !w_lock_h && (r_credit == WEIGHT_W'(1));
  assign w_decide  = (r_state == S_IDLE) ? w_any_req : (w_release || w_expire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grants   <= '0;
      r_idx      <= '0;
      r_last_idx <= IDX_W'(NUM_REQUESTERS - 1);
      r_credit   <= '0;
    end else if (w_decide) begin
      if (w_any_req) begin
        r_state    <= S_GRANT;
        r_grants   <= NUM_REQUESTERS'(1) << w_win_idx;
        r_idx      <= w_win_idx;
        r_last_idx <= w_win_idx;
        r_credit   <= w_load_credit;
      end else begin
        r_state  <= S_IDLE;
        r_grants <= '0;
        r_idx    <= '0;
        r_credit <= '0;
      end
    end else if (r_state == S_GRANT && w_beat && !w_lock_h) begin
      r_credit <= r_credit - WEIGHT_W'(1);
    end
  end

  assign o_grants      = r_grants;
  assign o_grant_valid = |r_grants;
  assign o_grant_idx   = r_idx;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed scenarios plus random traffic, all outputs
// checked against a behavioural model through an expected-value queue.
module tb_wrr_arbiter;
  localparam int N  = 4;
  localparam int WW = 4;
  localparam int IW = 2;
  localparam int EW = 1 + IW + N;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    i_requests;
  logic [N*WW-1:0] i_weights;
  logic [N-1:0]    i_lock;
  logic            i_mode;
  logic            i_ready;
  logic [N-1:0]    o_grants;
  logic            o_grant_valid;
  logic [IW-1:0]   o_grant_idx;
  logic            o_dbg_state;

  wrr_arbiter #(.NUM_REQUESTERS(N), .WEIGHT_W(WW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_requests   (i_requests),
    .i_weights    (i_weights),
    .i_lock       (i_lock),
    .i_mode       (i_mode),
    .i_ready      (i_ready),
    .o_grants     (o_grants),
    .o_grant_valid(o_grant_valid),
    .o_grant_idx  (o_grant_idx),
    .o_dbg_state  (o_dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic          mon_en = 1'b0;

  // reference model: holder (-1 = none), beats left, most recent holder
  int m_holder = -1;
  int m_credit = 0;
  int m_last   = N - 1;

  function automatic int pick(input logic [N-1:0] req, input logic mode);
    int order[$];
    if (mode) begin
      for (int k = 0; k < N; k++) order.push_back(k);
    end else begin
      for (int off = 1; off <= N; off++) order.push_back((m_last + off) % N);
    end
    foreach (order[j]) if (req[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic model_step();
    logic beat, dec, lk;
    int   w;
    logic [N-1:0]  g;
    logic [EW-1:0] e;
    beat = (m_holder >= 0) && i_ready;
    dec  = 1'b0;
    if (m_holder < 0) begin
      dec = |i_requests;
    end else begin
      lk = i_lock[m_holder];
      if (!lk && !i_requests[m_holder]) dec = 1'b1;
      else if (beat && !lk && m_credit == 1) dec = 1'b1;
      else if (beat && !lk) m_credit = m_credit - 1;
    end
    if (dec) begin
      if (|i_requests) begin
        w        = pick(i_requests, i_mode);
        m_holder = w;
        m_last   = w;
        m_credit = int'(i_weights[w*WW +: WW]);
        if (m_credit == 0) m_credit = 1;
      end else begin
        m_holder = -1;
      end
    end
    if (m_holder < 0) begin
      e = '0;
    end else begin
      g = '0;
      g[m_holder] = 1'b1;
      e = {1'b1, IW'(m_holder), g};
    end
    exp_q.push_back(e);
  endtask

  // driver tasks
  task automatic drive(input logic [N-1:0] req, input logic [N*WW-1:0] w,
                       input logic [N-1:0] lk, input logic mode, input logic rdy);
    @(negedge clk);
    i_requests = req;
    i_weights  = w;
    i_lock     = lk;
    i_mode     = mode;
    i_ready    = rdy;
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_grant_valid, o_grant_idx, o_grants} !== '0) begin
      errors++;
      $display("FAIL reset_async: got v=%0b idx=%0d g=%b, want all zero",
               o_grant_valid, o_grant_idx, o_grants);
    end
    m_holder = -1;
    m_credit = 0;
    m_last   = N - 1;
    exp_q.push_back('0);
    repeat (2) begin
      @(negedge clk);
      exp_q.push_back('0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_seq(input string name, input int got[$], input int want[$]);
    for (int i = 0; i < want.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] != want[i]) begin
        errors++;
        $display("FAIL %s[%0d]: got %0d, want %0d", name, i,
                 (i < got.size()) ? got[i] : -1, want[i]);
      end
    end
  endtask

  // scoreboard monitor
  logic [EW-1:0] mon_got, mon_exp;
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      mon_got = {o_grant_valid, o_grant_idx, o_grants};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got %b with nothing expected", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL grant @%0t: got v=%0b idx=%0d g=%b, want v=%0b idx=%0d g=%b",
                   $time, mon_got[EW-1], mon_got[N +: IW], mon_got[N-1:0],
                   mon_exp[EW-1], mon_exp[N +: IW], mon_exp[N-1:0]);
        end
      end
    end
  end

  initial begin
    int seq[$];
    int want30[$];
    int want31[$];
    logic [N-1:0] r_lk;
    want30 = '{0, 1, 2, 3, 0};
    want31 = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3};
    rst_n = 1'b0;
    i_requests = '0; i_weights = '0; i_lock = '0; i_mode = 1'b0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({o_grant_valid, o_grant_idx, o_grants, o_dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%0b idx=%0d g=%b st=%0b, want zeros",
               o_grant_valid, o_grant_idx, o_grants, o_dbg_state);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // plain round-robin, weights 1
    do_reset();
    seq = {};
    for (int i = 0; i < 5; i++) begin
      drive(4'hf, 16'h1111, 4'h0, 1'b0, 1'b1);
      @(posedge clk); #2;
      seq.push_back(int'(o_grant_idx));
    end
    check_seq("rr_basic", seq, want30);

    // weighted round-robin {3,1,2,1}
    do_reset();
    seq = {};
    for (int i = 0; i < 14; i++) begin
      drive(4'hf, 16'h1213, 4'h0, 1'b0, 1'b1);
      @(posedge clk); #2;
      seq.push_back(int'(o_grant_idx));
    end
    check_seq("wrr_weights", seq, want31);

    // lock holds requester 1 for 5 beats, then moves to 2
    do_reset();
    drive(4'b0010, 16'h1111, 4'h0, 1'b0, 1'b1);
    repeat (5) drive(4'b1111, 16'h1111, 4'b0010, 1'b0, 1'b1);
    repeat (3) drive(4'b1111, 16'h1111, 4'b0000, 1'b0, 1'b1);

    // fixed priority, late low-index request waits for credit to run out
    do_reset();
    drive(4'b1100, 16'h2222, 4'h0, 1'b1, 1'b1);
    repeat (4) drive(4'b1110, 16'h2222, 4'h0, 1'b1, 1'b1);

    // stalled downstream keeps grant, then release on request drop
    do_reset();
    drive(4'b1000, 16'h2222, 4'h0, 1'b0, 1'b1);
    repeat (10) drive(4'b1000, 16'h2222, 4'h0, 1'b0, 1'b0);
    drive(4'b0100, 16'h2222, 4'h0, 1'b0, 1'b0);
    repeat (2) drive(4'b0000, 16'h2222, 4'h0, 1'b0, 1'b1);

    // weight 0 behaves as 1; reset mid-grant then first arbitration as after power-up
    do_reset();
    drive(4'b0001, 16'h3330, 4'h0, 1'b0, 1'b1);
    drive(4'b0011, 16'h3330, 4'h0, 1'b0, 1'b1);
    do_reset();
    repeat (3) drive(4'b0110, 16'h1111, 4'h0, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      r_lk = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      drive(N'($urandom), (N*WW)'($urandom), r_lk,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end

    drive('0, '0, '0, 1'b0, 1'b1);
    @(posedge clk); #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
